// File: rtl/mips_pipe_pkg.sv
// Shared constants for the elastic pipeline register.
// PIPE_ELASTIC_SKID_EN adds one skid slot to the capacity.
package mips_pipe_pkg;

    localparam int PIPE_WIDTH = 32;
    localparam int PIPE_DEPTH = 2;

`ifdef PIPE_ELASTIC_SKID_EN
    localparam int PIPE_SKID_SLOTS = 1;
`else
    localparam int PIPE_SKID_SLOTS = 0;
`endif

    // Width of an occupancy counter that must represent 0..cap.
    function automatic int pipe_cnt_w(input int cap);
        return $clog2(cap + 1);
    endfunction

endpackage

// File: rtl/pipe_reg_elastic_stage.sv
// pipe_stage: one valid/data register slot of the elastic pipeline.
// Ports: clk, rst (async, high), flush, load, up_valid/up_data in, valid/data out.
module pipe_stage #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             load,
    input  logic             up_valid,
    input  logic [WIDTH-1:0] up_data,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= up_valid;
            // Data only moves with a real entry, so idle cycles cost no toggles.
            if (up_valid) begin
                data <= up_data;
            end
        end
    end

endmodule

// File: rtl/pipe_reg_elastic.sv
// pipe_reg_elastic: DEPTH-stage valid/ready register pipeline with bubble collapse.
// Ports: clk, rst (async, high), flush; in_valid/in_ready/in_data upstream;
// out_valid/out_ready/out_data downstream; count = entries held.
// Macro PIPE_ELASTIC_SKID_EN adds a one-entry input skid buffer (registered in_ready).
module pipe_reg_elastic
    import mips_pipe_pkg::*;
#(
    parameter int WIDTH = PIPE_WIDTH,
    parameter int DEPTH = PIPE_DEPTH,
    localparam int CAP = DEPTH + PIPE_SKID_SLOTS,
    localparam int CW  = pipe_cnt_w(CAP)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CW-1:0]    count
);

    logic             v   [DEPTH];
    logic [WIDTH-1:0] d   [DEPTH];
    logic             rdy [DEPTH];
    logic             uv  [DEPTH];
    logic [WIDTH-1:0] ud  [DEPTH];

    logic             accept;
    logic             out_xfer;
    logic             src_valid;
    logic [WIDTH-1:0] src_data;

    // A stage may load if it is empty or everything below it drains.
    always_comb begin : ready_chain
        logic acc;
        acc = out_ready;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            acc    = acc | ~v[i];
            rdy[i] = acc;
        end
    end

`ifdef PIPE_ELASTIC_SKID_EN
    logic             skid_valid;
    logic [WIDTH-1:0] skid_data;

    // in_ready depends only on state and flush, never on in_valid.
    assign in_ready  = ~skid_valid & ~flush;
    assign accept    = in_valid & in_ready;
    // A parked entry is older than anything arriving now, so it goes first.
    assign src_valid = skid_valid | accept;
    assign src_data  = skid_valid ? skid_data : in_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            skid_valid <= 1'b0;
            skid_data  <= '0;
        end else if (flush) begin
            skid_valid <= 1'b0;
        end else if (skid_valid && rdy[0]) begin
            skid_valid <= 1'b0;
        end else if (accept && !rdy[0]) begin
            skid_valid <= 1'b1;
            skid_data  <= in_data;
        end
    end
`else
    assign in_ready  = rdy[0] & ~flush;
    assign accept    = in_valid & in_ready;
    assign src_valid = accept;
    assign src_data  = in_data;
`endif

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        if (i == 0) begin : g_head
            assign uv[i] = src_valid;
            assign ud[i] = src_data;
        end else begin : g_body
            assign uv[i] = v[i-1];
            assign ud[i] = d[i-1];
        end

        pipe_stage #(
            .WIDTH (WIDTH)
        ) u_stage (
            .clk      (clk),
            .rst      (rst),
            .flush    (flush),
            .load     (rdy[i]),
            .up_valid (uv[i]),
            .up_data  (ud[i]),
            .valid    (v[i]),
            .data     (d[i])
        );
    end

    assign out_valid = v[DEPTH-1];
    assign out_data  = d[DEPTH-1];
    assign out_xfer  = out_valid & out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (flush) begin
            count <= '0;
        end else if (accept && !out_xfer) begin
            count <= count + CW'(1);
        end else if (!accept && out_xfer) begin
            count <= count - CW'(1);
        end
    end

endmodule

// File: tb/tb_pipe_reg_elastic.sv
// Bench for pipe_reg_elastic: DEPTH=2 and DEPTH=3 instances on shared stimulus,
// directed scenarios plus random traffic against a queue-of-positions model.
module tb_pipe_reg_elastic;

`ifdef PIPE_ELASTIC_SKID_EN
    localparam int SK = 1;
`else
    localparam int SK = 0;
`endif
    localparam int CW2 = $clog2(2 + SK + 1);
    localparam int CW3 = $clog2(3 + SK + 1);

    logic clk = 1'b0;
    logic rst;
    logic flush;
    logic in_valid;
    logic out_ready;
    logic [31:0] in_data;

    logic ir2, ov2, ir3, ov3;
    logic [31:0] od2, od3;
    logic [CW2-1:0] cnt2;
    logic [CW3-1:0] cnt3;

    always #5 clk = ~clk;

    pipe_reg_elastic #(.WIDTH(32), .DEPTH(2)) dut2 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(ir2), .in_data(in_data),
        .out_valid(ov2), .out_ready(out_ready), .out_data(od2),
        .count(cnt2)
    );

    pipe_reg_elastic #(.WIDTH(32), .DEPTH(3)) dut3 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(ir3), .in_data(in_data),
        .out_valid(ov3), .out_ready(out_ready), .out_data(od3),
        .count(cnt3)
    );

    // Model: each held item has a position 0..D-1; items keep arrival order.
    typedef int pq_t[$];
    typedef logic [31:0] dq_t[$];

    pq_t p2, p3;
    dq_t q2, q3;
    bit sv2, sv3;
    logic [31:0] sd2, sd3;

    int tests = 0;
    int fails = 0;

    // Position of each item after the coming edge; D means it left.
    function automatic pq_t m_np(int D, pq_t p, bit ordy);
        pq_t n;
        foreach (p[k]) begin
            if (k == 0)
                n.push_back((p[0] < D - 1) ? p[0] + 1 : (ordy ? D : p[0]));
            else
                n.push_back((p[k] + 1 < n[k-1]) ? p[k] + 1 : p[k]);
        end
        return n;
    endfunction

    // Position 0 can take a new item after the edge.
    function automatic bit m_r0(int D, pq_t p, bit ordy);
        pq_t n;
        n = m_np(D, p, ordy);
        if (p.size() == 0) return 1'b1;
        return !(p[p.size()-1] == 0 && n[n.size()-1] == 0);
    endfunction

    function automatic bit m_ir(int D, pq_t p, bit sv, bit fl, bit ordy);
        if (fl) return 1'b0;
        return (SK == 1) ? !sv : m_r0(D, p, ordy);
    endfunction

    task automatic mstep(input int D, input pq_t p, input dq_t q,
                         input bit sv, input logic [31:0] sd,
                         output pq_t po, output dq_t qo,
                         output bit svo, output logic [31:0] sdo);
        pq_t n;
        bit r0;
        bit acc;
        n   = m_np(D, p, out_ready);
        r0  = m_r0(D, p, out_ready);
        acc = in_valid && m_ir(D, p, sv, flush, out_ready);
        po  = {};
        qo  = {};
        svo = sv;
        sdo = sd;
        if (flush) begin
            svo = 1'b0;
            return;
        end
        foreach (n[k]) begin
            if (n[k] < D) begin
                po.push_back(n[k]);
                qo.push_back(q[k]);
            end
        end
        if (r0 && sv) begin
            po.push_back(0);
            qo.push_back(sd);
            svo = 1'b0;
        end
        if (acc) begin
            if (r0) begin
                po.push_back(0);
                qo.push_back(in_data);
            end else begin
                svo = 1'b1;
                sdo = in_data;
            end
        end
    endtask

    task automatic mreset();
        p2 = {}; q2 = {}; sv2 = 1'b0; sd2 = '0;
        p3 = {}; q3 = {}; sv3 = 1'b0; sd3 = '0;
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic mchk(string tag, int D, pq_t p, dq_t q, bit sv,
                        logic ir, logic ov, logic [31:0] od, int cnt);
        bit eov;
        eov = p.size() > 0 && p[0] == D - 1;
        chk({tag, ".in_ready"}, 32'(ir), 32'(m_ir(D, p, sv, flush, out_ready)));
        chk({tag, ".out_valid"}, 32'(ov), 32'(eov));
        if (eov) chk({tag, ".out_data"}, od, q[0]);
        chk({tag, ".count"}, 32'(cnt), 32'(p.size()) + 32'(sv));
    endtask

    // Check both DUTs against the model, then advance one clock.
    task automatic cyc();
        mchk("d2", 2, p2, q2, sv2, ir2, ov2, od2, int'(cnt2));
        mchk("d3", 3, p3, q3, sv3, ir3, ov3, od3, int'(cnt3));
        @(posedge clk);
        mstep(2, p2, q2, sv2, sd2, p2, q2, sv2, sd2);
        mstep(3, p3, q3, sv3, sd3, p3, q3, sv3, sd3);
        @(negedge clk);
    endtask

    task automatic drive(bit v, logic [31:0] dt, bit o, bit f);
        in_valid  = v;
        in_data   = dt;
        out_ready = o;
        flush     = f;
        #1;
    endtask

    task automatic clear();
        drive(1'b0, 32'h0, 1'b1, 1'b1);
        cyc();
    endtask

    initial begin
        mreset();
        rst = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        chk("rst.out_valid", 32'(ov2), 32'd0);
        chk("rst.out_data", od2, 32'd0);
        chk("rst.count", 32'(cnt2), 32'd0);
        chk("rst.in_ready", 32'(ir2), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        #1;

        // Streaming, out_ready high.
        drive(1'b1, 32'h1, 1'b1, 1'b0); cyc();
        drive(1'b1, 32'h2, 1'b1, 1'b0); cyc();
        drive(1'b1, 32'h3, 1'b1, 1'b0);
        chk("stream.c2.valid", 32'(ov2), 32'd1);
        chk("stream.c2.data", od2, 32'h1);
        chk("stream.c2.count", 32'(cnt2), 32'd2);
        cyc();
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        chk("stream.c3.data", od2, 32'h2);
        chk("stream.c3.count", 32'(cnt2), 32'd2);
        cyc();
        chk("stream.c4.data", od2, 32'h3);
        chk("stream.c4.count", 32'(cnt2), 32'd1);
        cyc();
        chk("stream.c5.valid", 32'(ov2), 32'd0);
        clear();

`ifndef PIPE_ELASTIC_SKID_EN
        // Back-pressure: two of three accepted, head held stable.
        drive(1'b1, 32'h1, 1'b0, 1'b0); cyc();
        drive(1'b1, 32'h2, 1'b0, 1'b0); cyc();
        drive(1'b1, 32'h3, 1'b0, 1'b0);
        chk("bp.in_ready", 32'(ir2), 32'd0);
        chk("bp.count", 32'(cnt2), 32'd2);
        chk("bp.data", od2, 32'h1);
        cyc();
        chk("bp.stable", od2, 32'h1);
        chk("bp.valid", 32'(ov2), 32'd1);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        chk("bp.drain0", od2, 32'h1);
        cyc();
        chk("bp.drain1", od2, 32'h2);
        cyc();
        chk("bp.empty", 32'(ov2), 32'd0);
        clear();
`else
        // Skid: third item parks, in_ready drops one cycle later.
        drive(1'b1, 32'h1, 1'b0, 1'b0); cyc();
        drive(1'b1, 32'h2, 1'b0, 1'b0); cyc();
        drive(1'b1, 32'h3, 1'b0, 1'b0);
        chk("skid.ir_at_3rd", 32'(ir2), 32'd1);
        cyc();
        drive(1'b1, 32'h4, 1'b0, 1'b0);
        chk("skid.ir_after", 32'(ir2), 32'd0);
        chk("skid.count", 32'(cnt2), 32'd3);
        chk("skid.head", od2, 32'h1);
        cyc();
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        chk("skid.drain0", od2, 32'h1);
        cyc();
        chk("skid.drain1", od2, 32'h2);
        cyc();
        chk("skid.drain2", od2, 32'h3);
        cyc();
        chk("skid.empty", 32'(ov2), 32'd0);
        clear();
`endif

        // Bubble collapse on DEPTH=3 with output stalled.
        drive(1'b1, 32'hA, 1'b0, 1'b0); cyc();
        drive(1'b0, 32'h0, 1'b0, 1'b0); cyc(); cyc();
        drive(1'b1, 32'hB, 1'b0, 1'b0);
        chk("bub.valid", 32'(ov3), 32'd1);
        chk("bub.data", od3, 32'hA);
        chk("bub.count1", 32'(cnt3), 32'd1);
        cyc();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        cyc();
        chk("bub.count2", 32'(cnt3), 32'd2);
        chk("bub.head", od3, 32'hA);
        chk("bub.in_ready", 32'(ir3), 32'd1);
        clear();

        // Flush with simultaneous input.
        drive(1'b1, 32'h11, 1'b0, 1'b0); cyc();
        drive(1'b1, 32'h22, 1'b0, 1'b0); cyc();
        drive(1'b1, 32'hDEAD, 1'b0, 1'b1);
        chk("fl.count_before", 32'(cnt2), 32'd2);
        chk("fl.in_ready2", 32'(ir2), 32'd0);
        chk("fl.in_ready3", 32'(ir3), 32'd0);
        cyc();
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        chk("fl.valid2", 32'(ov2), 32'd0);
        chk("fl.count2", 32'(cnt2), 32'd0);
        chk("fl.valid3", 32'(ov3), 32'd0);
        chk("fl.count3", 32'(cnt3), 32'd0);
        for (int i = 0; i < 5; i++) begin
            chk("fl.nodead",
                32'((ov2 && od2 == 32'hDEAD) || (ov3 && od3 == 32'hDEAD)),
                32'd0);
            cyc();
        end

        // Asynchronous reset between edges with two items held.
        drive(1'b1, 32'h31, 1'b0, 1'b0); cyc();
        drive(1'b1, 32'h32, 1'b0, 1'b0); cyc();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        chk("ar.count_before", 32'(cnt2), 32'd2);
        rst = 1'b1;
        #1;
        chk("ar.valid", 32'(ov2), 32'd0);
        chk("ar.data", od2, 32'd0);
        chk("ar.count", 32'(cnt2), 32'd0);
        chk("ar.count3", 32'(cnt3), 32'd0);
        chk("ar.in_ready", 32'(ir2), 32'd1);
        mreset();
        rst = 1'b0;
        drive(1'b1, 32'h41, 1'b1, 1'b0); cyc();
        drive(1'b1, 32'h42, 1'b1, 1'b0); cyc();
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        chk("ar.resume0", od2, 32'h41);
        cyc();
        chk("ar.resume1", od2, 32'h42);
        cyc();

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 1)), $urandom,
                  $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0);
            cyc();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pipe_reg_elastic.md
PIPE_REG_ELASTIC -- requirements
Module: pipe_reg_elastic

Interface
REQ-001 SHALL have parameter WIDTH, default 32: payload width in bits (>=1).
REQ-002 SHALL have parameter DEPTH, default 2: number of register stages (>=1).
REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port flush, input, 1: synchronous clear of all in-flight entries.
REQ-006 SHALL have port in_valid, input, 1: upstream payload present.
REQ-007 SHALL have port in_ready, output, 1: block accepts the upstream payload this cycle.
REQ-008 SHALL have port in_data, input, WIDTH: upstream payload.
REQ-009 SHALL have port out_valid, output, 1: final stage holds a valid entry.
REQ-010 SHALL have port out_ready, input, 1: downstream accepts this cycle.
REQ-011 SHALL have port out_data, output, WIDTH: final stage payload.
REQ-012 SHALL have port count, output, CW: number of valid entries held; CW = $clog2(CAP+1), where CAP is the capacity defined in REQ-029/REQ-030.

Function
REQ-013 SHALL transfer on a channel only when its valid and ready signals are both high at the rising clock edge.
REQ-014 SHALL hold a valid bit v[i] and a data register d[i] per stage i = 0..DEPTH-1; stage DEPTH-1 drives out_valid/out_data.
REQ-015 SHALL compute per-stage readiness: ready[DEPTH-1] = !v[DEPTH-1] | out_ready; ready[i] = !v[i] | ready[i+1].
REQ-016 SHALL drive in_ready = ready[0] & !flush.
REQ-017 SHALL load stage i when ready[i] is high: v[i] takes the upstream valid bit (in_valid & in_ready for i=0), and d[i] takes the upstream data only when that valid bit is 1.
REQ-018 SHALL hold v[i] and d[i] unchanged when ready[i] is low, so that out_data is stable while out_valid & !out_ready.
REQ-019 SHALL give a latency of exactly DEPTH cycles from input accept to out_valid when the pipe is empty and out_ready is held high.
REQ-020 SHALL sustain a throughput of one transfer per cycle when out_ready is held high.
REQ-021 SHALL collapse bubbles: an empty stage SHALL accept from upstream even when downstream is stalled.
REQ-022 SHALL, when flush is high, clear every v[i] at the next edge; flush SHALL have priority over any load, the d[i] values are don't-care, and no input is accepted in the flush cycle.
REQ-023 SHALL update count each cycle by +1 on input accept, -1 on output transfer, 0 when both or neither occur, and SHALL force it to 0 on flush.
REQ-024 SHALL never let count exceed CAP, or wrap below 0.
REQ-025 SHALL have no combinational path from in_valid to in_ready.

Reset
REQ-026 SHALL, while rst is high, force every v[i], d[i] and count to 0 immediately, regardless of clk.
REQ-027 SHALL hold out_valid = 0, out_data = 0 and count = 0 during reset; in_ready SHALL follow REQ-016 (1 when flush is low).
REQ-028 SHALL discard all in-flight entries if reset is asserted mid-stream, and SHALL resume from the empty state on the first edge after deassertion.

Configuration
REQ-029 SHALL, with macro PIPE_ELASTIC_SKID_EN defined, add a one-entry input skid buffer with these properties:
- in_ready is driven from a register (= !skid_valid & !flush).
- An input accepted while ready[0] is low is parked in the skid buffer and drained into stage 0 first.
- Latency through an empty skid is still DEPTH.
- CAP = DEPTH+1.
- flush and rst clear the skid buffer.
REQ-030 SHALL, without PIPE_ELASTIC_SKID_EN, behave exactly per REQ-016 with CAP = DEPTH and contain no skid logic.

Structure
REQ-031 SHALL take the default WIDTH/DEPTH constants and the CW width function from the shared package mips_pipe_pkg.
REQ-032 SHALL instantiate DEPTH copies of one sub-module, pipe_stage (ports: valid/data register, load, flush), using a generate loop.

Verification
REQ-033 SHALL verify streaming: DEPTH=2, out_ready=1, in_data 0x1,0x2,0x3 on consecutive cycles -> out_data 0x1,0x2,0x3 on cycles 2,3,4; count peaks at 2.
REQ-034 SHALL verify back-pressure: DEPTH=2, out_ready=0, 3 inputs offered -> 2 accepted, in_ready=0, count=2, out_data=0x1 stable; then out_ready=1 -> 0x1,0x2 drained in order.
REQ-035 SHALL verify bubble collapse: DEPTH=3, single item 0xA, out_ready=0 -> item reaches stage 2 after 3 cycles; a second item 0xB still advances to stage 1; count=2.
REQ-036 SHALL verify flush with simultaneous input: pipe holding 2 items, flush=1 with in_valid=1 -> in_ready=0, next cycle out_valid=0, count=0, and 0xDEAD never appears at the output.
REQ-037 SHALL verify asynchronous reset mid-stream: rst pulsed between clock edges with count=2 -> out_valid, out_data and count go to 0 before the next edge, and streaming resumes correctly.
REQ-038 SHALL verify the skid configuration: with PIPE_ELASTIC_SKID_EN defined, DEPTH=2, out_ready=0 -> 3 items accepted, count=3, in_ready falls the cycle after the third accept, and order is preserved on drain.
